// File: rtl/fft_pkg.sv
// Shared sizing helpers and sequencer state encoding for the in-place radix-2 FFT.
package fft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic int unsigned log2n(input int unsigned n);
        return $clog2(n);
    endfunction

    function automatic int unsigned addr_w(input int unsigned n);
        return log2n(n);
    endfunction

    function automatic int unsigned twid_w(input int unsigned n);
        return log2n(n) - 1;
    endfunction

    function automatic int unsigned stage_w(input int unsigned n);
        return $clog2(log2n(n) + 1);
    endfunction

    localparam int unsigned DEF_FFT_SIZE = 512;
    localparam int unsigned DEF_LOG2N    = log2n(DEF_FFT_SIZE);
    localparam int unsigned DEF_ADDR_W   = addr_w(DEF_FFT_SIZE);
    localparam int unsigned DEF_TWID_W   = twid_w(DEF_FFT_SIZE);

endpackage

// File: rtl/fft_bf_addr_gen.sv
// Maps (stage, butterfly index) to the top/bottom RAM addresses and twiddle index.
module fft_bf_addr_gen
    import fft_pkg::*;
#(
    parameter int unsigned FFT_SIZE = DEF_FFT_SIZE
) (
    input  logic [stage_w(FFT_SIZE)-1:0] i_stage,
    input  logic [addr_w(FFT_SIZE)-2:0]  i_k,
    output logic [addr_w(FFT_SIZE)-1:0]  o_top,
    output logic [addr_w(FFT_SIZE)-1:0]  o_bot,
    output logic [twid_w(FFT_SIZE)-1:0]  o_twiddle
);

    localparam int unsigned LOG2N = log2n(FFT_SIZE);
    localparam int unsigned AW    = addr_w(FFT_SIZE);
    localparam int unsigned TW    = twid_w(FFT_SIZE);
    localparam int unsigned SW    = stage_w(FFT_SIZE);

    logic [AW-1:0] k_ext;
    logic [AW-1:0] half;
    logic [AW-1:0] pos;

    // Split k into group and in-group position; groups are spaced 2*half apart.
    always_comb begin
        k_ext     = AW'(i_k);
        half      = AW'(1) << i_stage;
        pos       = k_ext & (half - AW'(1));
        o_top     = ((k_ext >> i_stage) << (i_stage + SW'(1))) | pos;
        o_bot     = o_top + half;
        o_twiddle = TW'(pos << (SW'(LOG2N - 1) - i_stage));
    end

endmodule

// File: rtl/fft_stage_sequencer.sv
// Stage sequencer for an in-place radix-2 DIT FFT over a dual-port registered RAM.
module fft_stage_sequencer
    import fft_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 48,
    parameter int unsigned FFT_SIZE   = DEF_FFT_SIZE,
    parameter int unsigned BF_LATENCY = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_start,
    output logic                         o_busy,
    output logic                         o_done,
    output logic [stage_w(FFT_SIZE)-1:0] o_stage,
    input  logic [addr_w(FFT_SIZE)-1:0]  i_ext_addr_a,
    input  logic [addr_w(FFT_SIZE)-1:0]  i_ext_addr_b,
    input  logic [DATA_WIDTH-1:0]        i_ext_data_a,
    input  logic [DATA_WIDTH-1:0]        i_ext_data_b,
    input  logic                         i_ext_wr_en_a,
    input  logic                         i_ext_wr_en_b,
    output logic [addr_w(FFT_SIZE)-1:0]  o_ram_addr_a,
    output logic [addr_w(FFT_SIZE)-1:0]  o_ram_addr_b,
    output logic [DATA_WIDTH-1:0]        o_ram_data_a,
    output logic [DATA_WIDTH-1:0]        o_ram_data_b,
    output logic                         o_ram_wr_en_a,
    output logic                         o_ram_wr_en_b,
    output logic                         o_bf_valid,
    output logic [twid_w(FFT_SIZE)-1:0]  o_bf_twiddle_idx,
    input  logic [DATA_WIDTH-1:0]        i_bf_data_a,
    input  logic [DATA_WIDTH-1:0]        i_bf_data_b
);

    localparam int unsigned LOG2N = log2n(FFT_SIZE);
    localparam int unsigned AW    = addr_w(FFT_SIZE);
    localparam int unsigned TW    = twid_w(FFT_SIZE);
    localparam int unsigned SW    = stage_w(FFT_SIZE);
    localparam int unsigned KW    = AW - 1;
    localparam int unsigned D     = BF_LATENCY + 1;

    localparam logic [KW-1:0] K_LAST     = KW'(FFT_SIZE / 2 - 1);
    localparam logic [SW-1:0] STAGE_LAST = SW'(LOG2N - 1);

    state_e               state_q, state_d;
    logic [SW-1:0]        stage_q, stage_d;
    logic [KW-1:0]        k_q, k_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 bf_valid_q, bf_valid_d;
    logic [TW-1:0]        twiddle_q, twiddle_d;
    logic [D-1:0]         pipe_vld_q, pipe_vld_d;
    logic [D-1:0][AW-1:0] pipe_top_q, pipe_top_d;
    logic [D-1:0][AW-1:0] pipe_bot_q, pipe_bot_d;

    logic                 rd_issue;
    logic                 wr_head;
    logic [AW-1:0]        gen_top;
    logic [AW-1:0]        gen_bot;
    logic [TW-1:0]        gen_twiddle;

    fft_bf_addr_gen #(
        .FFT_SIZE (FFT_SIZE)
    ) u_addr_gen (
        .i_stage   (stage_q),
        .i_k       (k_q),
        .o_top     (gen_top),
        .o_bot     (gen_bot),
        .o_twiddle (gen_twiddle)
    );

    // Next state: walk butterflies of a stage, write-back has priority over reads.
    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        k_d      = k_q;
        rd_issue = 1'b0;
        wr_head  = pipe_vld_q[D-1];

        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_RUN;
                    stage_d = '0;
                    k_d     = '0;
                end
            end
            ST_RUN: begin
                if (!wr_head) begin
                    rd_issue = 1'b1;
                    if (k_q == K_LAST) begin
                        k_d     = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (pipe_vld_q == '0) begin
                    if (stage_q == STAGE_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        stage_d = stage_q + SW'(1);
                        state_d = ST_RUN;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                stage_d = '0;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
        bf_valid_d = rd_issue;
        twiddle_d  = rd_issue ? gen_twiddle : '0;
    end

    // Write-back pipe: shifts every cycle, slot 0 takes the read issued this cycle.
    always_comb begin
        pipe_vld_d = {pipe_vld_q[D-2:0], rd_issue};
        pipe_top_d = {pipe_top_q[D-2:0], gen_top};
        pipe_bot_d = {pipe_bot_q[D-2:0], gen_bot};
    end

    // Registers; reset empties the pipe so an aborted run issues no further writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            stage_q    <= '0;
            k_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bf_valid_q <= 1'b0;
            twiddle_q  <= '0;
            pipe_vld_q <= '0;
            pipe_top_q <= '0;
            pipe_bot_q <= '0;
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            k_q        <= k_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bf_valid_q <= bf_valid_d;
            twiddle_q  <= twiddle_d;
            pipe_vld_q <= pipe_vld_d;
            pipe_top_q <= pipe_top_d;
            pipe_bot_q <= pipe_bot_d;
        end
    end

    // RAM port mux: external owner while idle, otherwise write-back then butterfly read.
    always_comb begin
        o_ram_addr_a  = '0;
        o_ram_addr_b  = '0;
        o_ram_data_a  = '0;
        o_ram_data_b  = '0;
        o_ram_wr_en_a = 1'b0;
        o_ram_wr_en_b = 1'b0;
        if (reset) begin
            if (state_q == ST_IDLE) begin
                o_ram_addr_a  = i_ext_addr_a;
                o_ram_addr_b  = i_ext_addr_b;
                o_ram_data_a  = i_ext_data_a;
                o_ram_data_b  = i_ext_data_b;
                o_ram_wr_en_a = i_ext_wr_en_a;
                o_ram_wr_en_b = i_ext_wr_en_b;
            end else if (wr_head) begin
                o_ram_addr_a  = pipe_top_q[D-1];
                o_ram_addr_b  = pipe_bot_q[D-1];
                o_ram_data_a  = i_bf_data_a;
                o_ram_data_b  = i_bf_data_b;
                o_ram_wr_en_a = 1'b1;
                o_ram_wr_en_b = 1'b1;
            end else if (rd_issue) begin
                o_ram_addr_a = gen_top;
                o_ram_addr_b = gen_bot;
            end
        end
    end

    assign o_busy           = busy_q;
    assign o_done           = done_q;
    assign o_stage          = stage_q;
    assign o_bf_valid       = bf_valid_q;
    assign o_bf_twiddle_idx = twiddle_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboarded bench: RAM and butterfly models around the sequencer, N=8.
module tb_fft_stage_sequencer;

    localparam int unsigned DW    = 48;
    localparam int unsigned N     = 8;
    localparam int unsigned BFL   = 2;
    localparam int unsigned LOG2N = 3;
    localparam int unsigned AW    = 3;
    localparam int unsigned TW    = 2;
    localparam int unsigned SW    = 2;
    localparam int unsigned WR_LAT = BFL + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_start;
    logic          o_busy, o_done;
    logic [SW-1:0] o_stage;
    logic [AW-1:0] i_ext_addr_a, i_ext_addr_b;
    logic [DW-1:0] i_ext_data_a, i_ext_data_b;
    logic          i_ext_wr_en_a, i_ext_wr_en_b;
    logic [AW-1:0] o_ram_addr_a, o_ram_addr_b;
    logic [DW-1:0] o_ram_data_a, o_ram_data_b;
    logic          o_ram_wr_en_a, o_ram_wr_en_b;
    logic          o_bf_valid;
    logic [TW-1:0] o_bf_twiddle_idx;
    logic [DW-1:0] i_bf_data_a, i_bf_data_b;

    fft_stage_sequencer #(
        .DATA_WIDTH (DW),
        .FFT_SIZE   (N),
        .BF_LATENCY (BFL)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .i_start          (i_start),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_stage          (o_stage),
        .i_ext_addr_a     (i_ext_addr_a),
        .i_ext_addr_b     (i_ext_addr_b),
        .i_ext_data_a     (i_ext_data_a),
        .i_ext_data_b     (i_ext_data_b),
        .i_ext_wr_en_a    (i_ext_wr_en_a),
        .i_ext_wr_en_b    (i_ext_wr_en_b),
        .o_ram_addr_a     (o_ram_addr_a),
        .o_ram_addr_b     (o_ram_addr_b),
        .o_ram_data_a     (o_ram_data_a),
        .o_ram_data_b     (o_ram_data_b),
        .o_ram_wr_en_a    (o_ram_wr_en_a),
        .o_ram_wr_en_b    (o_ram_wr_en_b),
        .o_bf_valid       (o_bf_valid),
        .o_bf_twiddle_idx (o_bf_twiddle_idx),
        .i_bf_data_a      (i_bf_data_a),
        .i_bf_data_b      (i_bf_data_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned top;
        int unsigned bot;
        int unsigned tw;
        int unsigned stage;
        int unsigned k;
    } bf_t;

    bf_t         exp_rd[$];
    bf_t         exp_wr[$];
    int unsigned iss_cyc[$];

    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;
    int unsigned wr_cnt = 0;
    int unsigned done_cnt = 0;
    int unsigned wpa [N];
    bit          mon_en = 1'b0;

    logic [DW-1:0] mem [N];
    logic [DW-1:0] model [N];
    logic [DW-1:0] ram_q_a, ram_q_b;
    logic [DW-1:0] p1a, p1b, p2a, p2b;
    logic [AW-1:0] prev_a, prev_b;

    function automatic logic [DW-1:0] bf_top(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input int unsigned tw);
        return a + b + DW'(tw);
    endfunction

    function automatic logic [DW-1:0] bf_bot(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return a - b;
    endfunction

    function automatic logic [DW-1:0] rand_word();
        return DW'({$urandom(), $urandom()});
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Registered dual-port RAM, read-before-write.
    always @(posedge clk) begin
        ram_q_a <= mem[o_ram_addr_a];
        ram_q_b <= mem[o_ram_addr_b];
        if (o_ram_wr_en_a) mem[o_ram_addr_a] <= o_ram_data_a;
        if (o_ram_wr_en_b) mem[o_ram_addr_b] <= o_ram_data_b;
    end

    // Butterfly model with BF_LATENCY cycles from RAM output to result.
    always @(posedge clk) begin
        p1a <= bf_top(ram_q_a, ram_q_b, int'(o_bf_twiddle_idx));
        p1b <= bf_bot(ram_q_a, ram_q_b);
        p2a <= p1a;
        p2b <= p1b;
    end
    assign i_bf_data_a = p2a;
    assign i_bf_data_b = p2b;

    // Monitor: pops expected reads/writes whenever the DUT presents them.
    always @(negedge clk) begin
        bf_t e;
        int unsigned c;
        cyc++;
        if (mon_en) begin
            if (o_bf_valid) begin
                if (exp_rd.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rd_unexpected actual=read required=none (t=%0t)", $time);
                end else begin
                    e = exp_rd.pop_front();
                    chk("rd_top", 64'(prev_a), 64'(e.top));
                    chk("rd_bot", 64'(prev_b), 64'(e.bot));
                    chk("rd_twiddle", 64'(o_bf_twiddle_idx), 64'(e.tw));
                    chk("rd_stage", 64'(o_stage), 64'(e.stage));
                    if (e.k == 0) chk("stage_order_writes", 64'(wr_cnt), 64'(e.stage * (N / 2)));
                    iss_cyc.push_back(cyc - 1);
                end
            end
            if (o_ram_wr_en_a || o_ram_wr_en_b) begin
                wr_cnt++;
                chk("wr_both_en", 64'({o_ram_wr_en_a, o_ram_wr_en_b}), 64'(2'b11));
                if (exp_wr.size() == 0 || iss_cyc.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL wr_unexpected actual=write required=none (t=%0t)", $time);
                end else begin
                    e = exp_wr.pop_front();
                    c = iss_cyc.pop_front();
                    chk("wr_top", 64'(o_ram_addr_a), 64'(e.top));
                    chk("wr_bot", 64'(o_ram_addr_b), 64'(e.bot));
                    chk("wr_latency", 64'(cyc - c), 64'(WR_LAT));
                    wpa[o_ram_addr_a]++;
                    wpa[o_ram_addr_b]++;
                end
            end
            if (o_done) done_cnt++;
        end
        prev_a = o_ram_addr_a;
        prev_b = o_ram_addr_b;
    end

    task automatic clear_ext();
        i_ext_addr_a  = '0;
        i_ext_addr_b  = '0;
        i_ext_data_a  = '0;
        i_ext_data_b  = '0;
        i_ext_wr_en_a = 1'b0;
        i_ext_wr_en_b = 1'b0;
    endtask

    // Load random samples through the external ports, two per cycle.
    task automatic load_ram();
        for (int i = 0; i < int'(N); i += 2) begin
            @(negedge clk);
            i_ext_addr_a  = AW'(i);
            i_ext_addr_b  = AW'(i + 1);
            i_ext_data_a  = rand_word();
            i_ext_data_b  = rand_word();
            i_ext_wr_en_a = 1'b1;
            i_ext_wr_en_b = 1'b1;
            model[i]      = i_ext_data_a;
            model[i + 1]  = i_ext_data_b;
        end
        @(negedge clk);
        clear_ext();
    endtask

    // Reference: group/offset enumeration of every stage, plus the final RAM image.
    task automatic build_expected();
        bf_t e;
        logic [DW-1:0] a, b;
        exp_rd.delete();
        exp_wr.delete();
        iss_cyc.delete();
        for (int s = 0; s < int'(LOG2N); s++) begin
            int half;
            int span;
            int k;
            half = 1 << s;
            span = 2 * half;
            k    = 0;
            for (int base = 0; base < int'(N); base += span) begin
                for (int j = 0; j < half; j++) begin
                    e.top   = base + j;
                    e.bot   = base + j + half;
                    e.tw    = j * (int'(N) / span);
                    e.stage = s;
                    e.k     = k;
                    exp_rd.push_back(e);
                    exp_wr.push_back(e);
                    a = model[e.top];
                    b = model[e.bot];
                    model[e.top] = bf_top(a, b, e.tw);
                    model[e.bot] = bf_bot(a, b);
                    k++;
                end
            end
        end
    endtask

    task automatic run_fft(input bit ext_noise);
        int t;
        wr_cnt   = 0;
        done_cnt = 0;
        for (int i = 0; i < int'(N); i++) wpa[i] = 0;
        mon_en = 1'b1;
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        if (ext_noise) begin
            i_ext_addr_a  = AW'(5);
            i_ext_data_a  = DW'(48'hABC);
            i_ext_wr_en_a = 1'b1;
            i_ext_addr_b  = AW'(6);
            i_ext_wr_en_b = 1'b1;
        end
        #1;
        chk("busy_after_start", 64'(o_busy), 64'(1));
        if (ext_noise) begin
            chk("run_ext_wr_a_blocked", 64'(o_ram_wr_en_a), 64'(0));
            chk("run_ext_addr_a_blocked", 64'(o_ram_addr_a), 64'(0));
            chk("run_ext_addr_b_blocked", 64'(o_ram_addr_b), 64'(1));
        end
        t = 0;
        while (!o_done && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", 64'(o_done), 64'(1));
        clear_ext();
        @(negedge clk);
        @(negedge clk);
        chk("busy_after_done", 64'(o_busy), 64'(0));
        chk("done_once", 64'(done_cnt), 64'(1));
        chk("write_total", 64'(wr_cnt), 64'((N / 2) * LOG2N));
        chk("reads_left", 64'(exp_rd.size()), 64'(0));
        mon_en = 1'b0;
    endtask

    // Read every word back through external port A and compare with the reference.
    task automatic unload_check();
        for (int i = 0; i < int'(N); i++) begin
            @(negedge clk);
            i_ext_addr_a = AW'(i);
            @(negedge clk);
            chk($sformatf("ram_word_%0d", i), 64'(ram_q_a), 64'(model[i]));
            chk($sformatf("writes_addr_%0d", i), 64'(wpa[i]), 64'(LOG2N));
        end
        clear_ext();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        reset   = 1'b0;
        i_start = 1'b0;
        clear_ext();
        i_ext_wr_en_a = 1'b1;
        #1;
        chk("rst_busy", 64'(o_busy), 64'(0));
        chk("rst_done", 64'(o_done), 64'(0));
        chk("rst_bf_valid", 64'(o_bf_valid), 64'(0));
        chk("rst_wr_en_a", 64'(o_ram_wr_en_a), 64'(0));
        chk("rst_wr_en_b", 64'(o_ram_wr_en_b), 64'(0));
        chk("rst_stage", 64'(o_stage), 64'(0));
        chk("rst_twiddle", 64'(o_bf_twiddle_idx), 64'(0));
        i_ext_wr_en_a = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Full run with clean external inputs.
        load_ram();
        build_expected();
        run_fft(1'b0);
        unload_check();

        // Abort in the middle of stage 1.
        load_ram();
        build_expected();
        mon_en = 1'b1;
        wr_cnt = 0;
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        t = 0;
        while (o_stage != SW'(1) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("abort_reached_stage1", 64'(o_stage), 64'(1));
        @(negedge clk);
        @(negedge clk);
        mon_en        = 1'b0;
        i_ext_addr_a  = AW'(5);
        i_ext_wr_en_a = 1'b1;
        i_ext_wr_en_b = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("abort_busy", 64'(o_busy), 64'(0));
        chk("abort_wr_en_a", 64'(o_ram_wr_en_a), 64'(0));
        chk("abort_wr_en_b", 64'(o_ram_wr_en_b), 64'(0));
        chk("abort_bf_valid", 64'(o_bf_valid), 64'(0));
        chk("abort_stage", 64'(o_stage), 64'(0));
        @(negedge clk);
        clear_ext();
        exp_rd.delete();
        exp_wr.delete();
        iss_cyc.delete();
        @(negedge clk);
        reset = 1'b1;

        // Idle passthrough after the abort.
        @(negedge clk);
        i_ext_addr_a  = AW'(5);
        i_ext_data_a  = DW'(48'hABC);
        i_ext_wr_en_a = 1'b1;
        i_ext_addr_b  = AW'($urandom_range(0, N - 1));
        i_ext_data_b  = rand_word();
        i_ext_wr_en_b = 1'b0;
        #1;
        chk("idle_addr_a", 64'(o_ram_addr_a), 64'(5));
        chk("idle_data_a", 64'(o_ram_data_a), 64'(48'hABC));
        chk("idle_wr_en_a", 64'(o_ram_wr_en_a), 64'(1));
        chk("idle_addr_b", 64'(o_ram_addr_b), 64'(i_ext_addr_b));
        chk("idle_data_b", 64'(o_ram_data_b), 64'(i_ext_data_b));
        chk("idle_wr_en_b", 64'(o_ram_wr_en_b), 64'(0));
        chk("idle_busy", 64'(o_busy), 64'(0));
        @(negedge clk);
        clear_ext();

        // Restart from stage 0 with external inputs toggling during the run.
        load_ram();
        build_expected();
        run_fft(1'b1);
        unload_check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
